// File: rtl/types_pkg.sv
// Shared RV32I control types: ALU operations, immediate formats, sequencer states and opcodes.
package types_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5
    } alu_ctrl_t;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } instr_format_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } ctrl_state_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational opcode/funct decode for the supported RV32I subset; zero latency.
// Unsupported encodings drop 'legal' and leave every other output at its default.
module instr_decode
    import types_pkg::*;
(
    input  logic [6:0]    opcode,
    input  logic [2:0]    funct3,
    input  logic [6:0]    funct7,
    output logic          legal,
    output alu_ctrl_t     alu_ctrl,
    output logic          alu_src,
    output instr_format_t imm_src,
    output logic          result_src,
    output logic          is_load,
    output logic          is_store,
    output logic          is_branch
);

    always_comb begin
        legal      = 1'b0;
        alu_ctrl   = ALU_ADD;
        alu_src    = 1'b0;
        imm_src    = FMT_R;
        result_src = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_branch  = 1'b0;
        case (opcode)
            OP_IMM: begin
                if (funct3 == F3_ADD) begin
                    legal   = 1'b1;
                    alu_src = 1'b1;
                    imm_src = FMT_I;
                end
            end
            OP_REG: begin
                if (funct3 == F3_ADD && (funct7 == F7_ADD || funct7 == F7_SUB)) begin
                    legal    = 1'b1;
                    alu_ctrl = (funct7 == F7_SUB) ? ALU_SUB : ALU_ADD;
                end
            end
            OP_LOAD: begin
                if (funct3 == F3_W) begin
                    legal      = 1'b1;
                    alu_src    = 1'b1;
                    imm_src    = FMT_I;
                    result_src = 1'b1;
                    is_load    = 1'b1;
                end
            end
            OP_STORE: begin
                if (funct3 == F3_W) begin
                    legal    = 1'b1;
                    alu_src  = 1'b1;
                    imm_src  = FMT_S;
                    is_store = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
                    legal     = 1'b1;
                    alu_ctrl  = ALU_SUB;
                    imm_src   = FMT_B;
                    is_branch = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: ALU op 4 cycles, branch 3, SW 4, LW 5 with zero-wait memories;
// memory stalls hold the request indefinitely, or trap after TIMEOUT_CYCLES when MEM_TIMEOUT_EN is defined.
module multicycle_ctrl
    import types_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int INSTRET_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr,
    input  logic                 eq,
    input  logic                 imem_ready,
    input  logic                 mem_ready,
    output logic                 imem_req,
    output logic                 ir_we,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 reg_write,
    output logic                 result_src,
    output logic                 alu_src,
    output alu_ctrl_t            alu_ctrl,
    output instr_format_t        imm_src,
    output logic                 pc_we,
    output logic                 pc_src,
    output logic                 retire,
    output logic [INSTRET_W-1:0] instret,
    output logic                 trap
);

    ctrl_state_t state_q, state_d;
    logic [6:0]  op_q;
    logic [2:0]  f3_q;
    logic [6:0]  f7_q;

    logic [6:0]    dec_op;
    logic [2:0]    dec_f3;
    logic [6:0]    dec_f7;
    logic          dec_legal;
    alu_ctrl_t     dec_alu_ctrl;
    logic          dec_alu_src;
    instr_format_t dec_imm_src;
    logic          dec_result_src;
    logic          dec_is_load;
    logic          dec_is_store;
    logic          dec_is_branch;
    logic          timeout;

    // DECODE judges the live IR; later states use the fields latched on leaving DECODE.
    assign dec_op = (state_q == S_DECODE) ? instr[6:0]   : op_q;
    assign dec_f3 = (state_q == S_DECODE) ? instr[14:12] : f3_q;
    assign dec_f7 = (state_q == S_DECODE) ? instr[31:25] : f7_q;

    logic unused_instr;
    assign unused_instr = ^{instr[24:15], instr[11:7]};

    instr_decode u_decode (
        .opcode     (dec_op),
        .funct3     (dec_f3),
        .funct7     (dec_f7),
        .legal      (dec_legal),
        .alu_ctrl   (dec_alu_ctrl),
        .alu_src    (dec_alu_src),
        .imm_src    (dec_imm_src),
        .result_src (dec_result_src),
        .is_load    (dec_is_load),
        .is_store   (dec_is_store),
        .is_branch  (dec_is_branch)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Counter restarts on every state change, so it measures time spent in the current wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state_d != state_q) begin
            wait_cnt <= '0;
        end else if ((state_q == S_FETCH && !imem_ready) || (state_q == S_MEM && !mem_ready)) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            f3_q    <= '0;
            f7_q    <= '0;
            instret <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= instr[6:0];
                f3_q <= instr[14:12];
                f7_q <= instr[31:25];
            end
            if (retire) begin
                instret <= instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        reg_write  = 1'b0;
        result_src = 1'b0;
        alu_src    = 1'b0;
        alu_ctrl   = ALU_ADD;
        imm_src    = FMT_R;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        retire     = 1'b0;

        // ALU controls stay stable from EXEC through the end of the instruction.
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            alu_src  = dec_alu_src;
            alu_ctrl = dec_alu_ctrl;
            imm_src  = dec_imm_src;
        end

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: state_d = dec_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (dec_is_branch) begin
                    pc_we   = 1'b1;
                    pc_src  = (f3_q == F3_BNE) ? ~eq : eq;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (dec_is_load || dec_is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = dec_is_store;
                if (mem_ready) begin
                    if (dec_is_store) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                result_src = dec_result_src;
                pc_we      = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    assign trap = (state_q == S_TRAP);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction expectations queued at issue, checked at retire.
module tb_multicycle_ctrl;
    import types_pkg::*;

    logic          clk;
    logic          rst;
    logic [31:0]   instr;
    logic          eq;
    logic          imem_ready;
    logic          mem_ready;
    logic          imem_req;
    logic          ir_we;
    logic          mem_req;
    logic          mem_we;
    logic          reg_write;
    logic          result_src;
    logic          alu_src;
    alu_ctrl_t     alu_ctrl;
    instr_format_t imm_src;
    logic          pc_we;
    logic          pc_src;
    logic          retire;
    logic [31:0]   instret;
    logic          trap;

    multicycle_ctrl #(.TIMEOUT_CYCLES(16), .INSTRET_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .eq         (eq),
        .imem_ready (imem_ready),
        .mem_ready  (mem_ready),
        .imem_req   (imem_req),
        .ir_we      (ir_we),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src    (alu_src),
        .alu_ctrl   (alu_ctrl),
        .imm_src    (imm_src),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .retire     (retire),
        .instret    (instret),
        .trap       (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        int          irwe;
        int          mreq;
        logic        rw;
        logic        rs;
        logic        pcwe;
        logic        psrc;
        logic        mwe;
        logic        asrc;
        logic [2:0]  isrc;
        logic [2:0]  actl;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   model_cnt = 0;
    int   passed = 0;
    int   total = 0;

    localparam logic [31:0] I_ADDI = 32'h00500513;
    localparam logic [31:0] I_ADD  = 32'h00B50533;
    localparam logic [31:0] I_SUB  = 32'h40B50533;
    localparam logic [31:0] I_BNE  = 32'h00051463;
    localparam logic [31:0] I_BEQ  = 32'h00050463;
    localparam logic [31:0] I_LW   = 32'h00052583;
    localparam logic [31:0] I_SW   = 32'h00B52023;
    localparam logic [31:0] I_ILL  = 32'h0000007F;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int lat, input int mreq, input logic rw, input logic rs,
                                input logic psrc, input logic mwe, input logic asrc,
                                input instr_format_t isrc, input alu_ctrl_t actl);
        exp_t e;
        e.lat  = lat;
        e.irwe = 1;
        e.mreq = mreq;
        e.rw   = rw;
        e.rs   = rs;
        e.pcwe = 1'b1;
        e.psrc = psrc;
        e.mwe  = mwe;
        e.asrc = asrc;
        e.isrc = isrc;
        e.actl = actl;
        e.cnt  = '0;
        return e;
    endfunction

    // Entered at a sample point with the DUT in FETCH; returns one cycle after retire.
    // mem_wait < 0 keeps mem_ready high in every state.
    task automatic issue(input string nm, input logic [31:0] ins, input logic eq_v,
                         input int mem_wait, input exp_t e_in);
        exp_t e, x;
        int   lat, irwe, mreq;
        logic rw, rs, mwe, done, psrc, pcwe, asrc;
        logic [2:0] isrc, actl;
        e = e_in;
        model_cnt++;
        e.cnt = model_cnt;
        sb.push_back(e);
        instr = ins;
        eq = eq_v;
        imem_ready = 1'b1;
        lat = 0; irwe = 0; mreq = 0;
        rw = 0; rs = 0; mwe = 0; done = 0; psrc = 0; pcwe = 0; asrc = 0; isrc = '0; actl = '0;
        for (int c = 0; c < 60 && !done; c++) begin
            #1;
            mem_ready = (mem_wait < 0) ? 1'b1 : (mem_req && mreq >= mem_wait);
            #1;
            lat++;
            if (ir_we) irwe++;
            if (mem_req) begin
                mreq++;
                mwe = mwe | mem_we;
            end
            if (reg_write) begin
                rw = 1'b1;
                rs = result_src;
            end
            if (retire) begin
                done = 1'b1;
                pcwe = pc_we;
                psrc = pc_src;
                asrc = alu_src;
                isrc = imm_src;
                actl = alu_ctrl;
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        x = sb.pop_front();
        chk({nm, "_retired"}, done, 1);
        chk({nm, "_latency"}, lat, x.lat);
        chk({nm, "_ir_we"}, irwe, x.irwe);
        chk({nm, "_mem_req_cycles"}, mreq, x.mreq);
        chk({nm, "_mem_we"}, mwe, x.mwe);
        chk({nm, "_reg_write"}, rw, x.rw);
        chk({nm, "_result_src"}, rs, x.rs);
        chk({nm, "_pc_we"}, pcwe, x.pcwe);
        chk({nm, "_pc_src"}, psrc, x.psrc);
        chk({nm, "_alu_src"}, asrc, x.asrc);
        chk({nm, "_imm_src"}, isrc, x.isrc);
        chk({nm, "_alu_ctrl"}, actl, x.actl);
        #1;
        chk({nm, "_retire_pulse"}, retire, 0);
        chk({nm, "_instret"}, instret, x.cnt);
    endtask

    // Runs the IDLE cycle after reset release and confirms the fetch request in the next one.
    task automatic release_reset(input string nm);
        @(negedge clk);
        rst = 1'b0;
        imem_ready = 1'b1;
        #1;
        chk({nm, "_idle_no_req"}, imem_req, 0);
        @(negedge clk);
        #1;
        chk({nm, "_fetch_req"}, imem_req, 1);
    endtask

    task automatic run_to_mem(input string nm);
        logic found;
        instr = I_LW;
        mem_ready = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            #1;
            if (mem_req) found = 1'b1;
            else @(negedge clk);
        end
        chk({nm, "_mem_reached"}, found, 1);
    endtask

    initial begin
        int bad;
        int n;
        rst = 1'b1;
        instr = '0;
        eq = 1'b0;
        imem_ready = 1'b0;
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_strobes", {ir_we, mem_we, reg_write, pc_we, retire}, 0);
        chk("rst_instret", instret, 0);
        chk("rst_trap", trap, 0);

        release_reset("boot");
        issue("addi",   I_ADDI, 1'b0, -1, mk(4, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, FMT_I, ALU_ADD));
        issue("add",    I_ADD,  1'b0, -1, mk(4, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FMT_R, ALU_ADD));
        issue("sub",    I_SUB,  1'b0, -1, mk(4, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FMT_R, ALU_SUB));
        issue("bne_ne", I_BNE,  1'b0, -1, mk(3, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FMT_B, ALU_SUB));
        issue("bne_eq", I_BNE,  1'b1, -1, mk(3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FMT_B, ALU_SUB));
        issue("beq_eq", I_BEQ,  1'b1, -1, mk(3, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, FMT_B, ALU_SUB));
        issue("lw_w3",  I_LW,   1'b0,  3, mk(8, 4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, FMT_I, ALU_ADD));
        issue("sw",     I_SW,   1'b0, -1, mk(4, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, FMT_S, ALU_ADD));
        issue("lw_w0",  I_LW,   1'b0,  0, mk(5, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, FMT_I, ALU_ADD));

        // Abort a stalled load with an asynchronous reset.
        run_to_mem("abort");
        repeat (2) @(negedge clk);
        #1;
        chk("abort_stalled_req", mem_req, 1);
        rst = 1'b1;
        #1;
        chk("abort_mem_req_drop", mem_req, 0);
        chk("abort_imem_req", imem_req, 0);
        chk("abort_no_retire", retire, 0);
        chk("abort_instret", instret, 0);
        model_cnt = 0;
        release_reset("after_abort");

        run_to_mem("stall");
`ifdef MEM_TIMEOUT_EN
        n = 0;
        for (int c = 0; c < 40 && !trap; c++) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("timeout_cycles", n, 16);
        chk("timeout_trap", trap, 1);
        chk("timeout_req_drop", mem_req, 0);
`else
        repeat (100) @(negedge clk);
        #1;
        chk("stall_mem_req", mem_req, 1);
        chk("stall_no_trap", trap, 0);
        chk("stall_no_retire", retire, 0);
`endif

        @(negedge clk);
        rst = 1'b1;
        release_reset("before_trap");
        instr = I_ILL;
        repeat (2) @(negedge clk);
        #1;
        chk("illegal_trap", trap, 1);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (!trap || imem_req || mem_req || ir_we || reg_write || pc_we || retire) bad++;
        end
        chk("trap_sticky_quiet", bad, 0);
        chk("trap_instret", instret, model_cnt);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
